// File: rtl/blue_filter_pkg.sv
// Shared constants and FSM state types for the blue filter AXI4-Lite control port.
package blue_filter_pkg;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

    localparam logic [3:0] REG_CTRL    = 4'h0;
    localparam logic [3:0] REG_THRESH  = 4'h4;
    localparam logic [3:0] REG_GAIN    = 4'h8;
    localparam logic [3:0] REG_SCRATCH = 4'hC;

    typedef enum logic {
        W_IDLE,
        W_RESP
    } wr_state_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rd_state_t;

endpackage

// File: rtl/blue_filter_axil_slave.sv
// AXI4-Lite register-file responder for the blue filter control port.
//
// state  | meaning
// -------+----------------------------------------------------------------
// W_IDLE | accepting AW and W independently; commit once both are present
// W_RESP | write committed, BVALID high, AW/W back-pressured until BREADY
// R_IDLE | ARREADY high, waiting for a read address
// R_DATA | RVALID high, RDATA held stable until RREADY
module blue_filter_axil_slave
    import blue_filter_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4,
    parameter int NUM_REGS           = 4
) (
    input  logic                              S_AXI_ACLK,
    input  logic                              S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [2:0]                        S_AXI_AWPROT,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [2:0]                        S_AXI_ARPROT,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,
    output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_o,
    output logic [NUM_REGS-1:0]               reg_wr_o
);

    localparam int DW    = C_S_AXI_DATA_WIDTH;
    localparam int SW    = C_S_AXI_DATA_WIDTH / 8;
    localparam int IDX_W = C_S_AXI_ADDR_WIDTH - 2;

    logic [DW-1:0]    regs [NUM_REGS];

    wr_state_t        wr_state, wr_state_nxt;
    rd_state_t        rd_state, rd_state_nxt;

    logic             aw_held, w_held;
    logic [IDX_W-1:0] aw_idx_q;
    logic [DW-1:0]    w_data_q;
    logic [SW-1:0]    w_strb_q;

    logic             aw_hs, w_hs, ar_hs;
    logic             aw_avail, w_avail, commit;
    logic [IDX_W-1:0] wr_idx, rd_idx;
    logic [DW-1:0]    wr_data;
    logic [SW-1:0]    wr_strb;

    // Protection bits and byte-lane address bits carry no meaning here.
    logic             unused_ok;
    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    assign S_AXI_AWREADY = (wr_state == W_IDLE) && !aw_held;
    assign S_AXI_WREADY  = (wr_state == W_IDLE) && !w_held;
    assign S_AXI_BVALID  = (wr_state == W_RESP);
    assign S_AXI_BRESP   = AXI_RESP_OKAY;
    assign S_AXI_ARREADY = (rd_state == R_IDLE);
    assign S_AXI_RVALID  = (rd_state == R_DATA);
    assign S_AXI_RRESP   = AXI_RESP_OKAY;

    assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_hs  = S_AXI_WVALID  && S_AXI_WREADY;
    assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

    // A channel counts as present if it was held earlier or handshakes this
    // cycle, so a same-cycle AW+W commits at the handshake edge itself.
    assign aw_avail = aw_held || aw_hs;
    assign w_avail  = w_held  || w_hs;
    assign commit   = (wr_state == W_IDLE) && aw_avail && w_avail;

    assign wr_idx  = aw_held ? aw_idx_q : S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
    assign wr_data = w_held  ? w_data_q : S_AXI_WDATA;
    assign wr_strb = w_held  ? w_strb_q : S_AXI_WSTRB;
    assign rd_idx  = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];

    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_flat
        assign reg_o[gi*DW +: DW] = regs[gi];
    end

    // Write FSM next state: commit moves to response, BREADY releases it.
    always_comb begin
        wr_state_nxt = wr_state;
        case (wr_state)
            W_IDLE:  if (commit)       wr_state_nxt = W_RESP;
            W_RESP:  if (S_AXI_BREADY) wr_state_nxt = W_IDLE;
            default:                   wr_state_nxt = W_IDLE;
        endcase
    end

    // Write path: state, AW/W holding registers, register commit and strobe pulse.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            wr_state <= W_IDLE;
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            aw_idx_q <= '0;
            w_data_q <= '0;
            w_strb_q <= '0;
            reg_wr_o <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            wr_state <= wr_state_nxt;
            reg_wr_o <= '0;
            if (commit) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
                for (int b = 0; b < SW; b++) begin
                    if (wr_strb[b]) regs[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
                reg_wr_o[wr_idx] <= 1'b1;
            end else begin
                if (aw_hs) begin
                    aw_held  <= 1'b1;
                    aw_idx_q <= S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
                end
                if (w_hs) begin
                    w_held   <= 1'b1;
                    w_data_q <= S_AXI_WDATA;
                    w_strb_q <= S_AXI_WSTRB;
                end
            end
        end
    end

    // Read FSM next state: AR handshake loads data, RREADY returns to idle.
    always_comb begin
        rd_state_nxt = rd_state;
        case (rd_state)
            R_IDLE:  if (ar_hs)        rd_state_nxt = R_DATA;
            R_DATA:  if (S_AXI_RREADY) rd_state_nxt = R_IDLE;
            default:                   rd_state_nxt = R_IDLE;
        endcase
    end

    // Read path: RDATA samples the register array before any same-edge commit lands.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            rd_state    <= R_IDLE;
            S_AXI_RDATA <= '0;
        end else begin
            rd_state <= rd_state_nxt;
            if (ar_hs) S_AXI_RDATA <= regs[rd_idx];
        end
    end

endmodule

// File: tb/tb_blue_filter_axil_slave.sv
// Self-checking bench for blue_filter_axil_slave: read data scored via an expected-value queue.
module tb_blue_filter_axil_slave;
    import blue_filter_pkg::*;

    logic         S_AXI_ACLK = 1'b0;
    logic         S_AXI_ARESETN = 1'b0;
    logic [3:0]   S_AXI_AWADDR = '0;
    logic [2:0]   S_AXI_AWPROT = '0;
    logic         S_AXI_AWVALID = 1'b0;
    logic         S_AXI_AWREADY;
    logic [31:0]  S_AXI_WDATA = '0;
    logic [3:0]   S_AXI_WSTRB = '0;
    logic         S_AXI_WVALID = 1'b0;
    logic         S_AXI_WREADY;
    logic [1:0]   S_AXI_BRESP;
    logic         S_AXI_BVALID;
    logic         S_AXI_BREADY = 1'b1;
    logic [3:0]   S_AXI_ARADDR = '0;
    logic [2:0]   S_AXI_ARPROT = '0;
    logic         S_AXI_ARVALID = 1'b0;
    logic         S_AXI_ARREADY;
    logic [31:0]  S_AXI_RDATA;
    logic [1:0]   S_AXI_RRESP;
    logic         S_AXI_RVALID;
    logic         S_AXI_RREADY = 1'b1;
    logic [127:0] reg_o;
    logic [3:0]   reg_wr_o;

    int           n_checks = 0;
    int           n_fail   = 0;
    logic [31:0]  model [4];
    logic [31:0]  exp_q [$];
    int           wr_cnt [4];

    blue_filter_axil_slave dut (
        .S_AXI_ACLK    (S_AXI_ACLK),
        .S_AXI_ARESETN (S_AXI_ARESETN),
        .S_AXI_AWADDR  (S_AXI_AWADDR),
        .S_AXI_AWPROT  (S_AXI_AWPROT),
        .S_AXI_AWVALID (S_AXI_AWVALID),
        .S_AXI_AWREADY (S_AXI_AWREADY),
        .S_AXI_WDATA   (S_AXI_WDATA),
        .S_AXI_WSTRB   (S_AXI_WSTRB),
        .S_AXI_WVALID  (S_AXI_WVALID),
        .S_AXI_WREADY  (S_AXI_WREADY),
        .S_AXI_BRESP   (S_AXI_BRESP),
        .S_AXI_BVALID  (S_AXI_BVALID),
        .S_AXI_BREADY  (S_AXI_BREADY),
        .S_AXI_ARADDR  (S_AXI_ARADDR),
        .S_AXI_ARPROT  (S_AXI_ARPROT),
        .S_AXI_ARVALID (S_AXI_ARVALID),
        .S_AXI_ARREADY (S_AXI_ARREADY),
        .S_AXI_RDATA   (S_AXI_RDATA),
        .S_AXI_RRESP   (S_AXI_RRESP),
        .S_AXI_RVALID  (S_AXI_RVALID),
        .S_AXI_RREADY  (S_AXI_RREADY),
        .reg_o         (reg_o),
        .reg_wr_o      (reg_wr_o)
    );

    always #5 S_AXI_ACLK = ~S_AXI_ACLK;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Read scoreboard: compare on the cycle the R handshake completes.
    always @(negedge S_AXI_ACLK) begin
        if (S_AXI_ARESETN && S_AXI_RVALID && S_AXI_RREADY) begin
            if (exp_q.size() == 0) begin
                check("r_unexpected", S_AXI_RVALID, 1'b0);
            end else begin
                check("rdata", S_AXI_RDATA, exp_q.pop_front());
                check("rresp", S_AXI_RRESP, AXI_RESP_OKAY);
            end
        end
    end

    // Count write-strobe pulses per register.
    always @(negedge S_AXI_ACLK) begin
        for (int i = 0; i < 4; i++) if (reg_wr_o[i] === 1'b1) wr_cnt[i]++;
    end

    task automatic clear_wr_cnt();
        for (int i = 0; i < 4; i++) wr_cnt[i] = 0;
    endtask

    task automatic send_aw(input logic [3:0] a);
        int n = 0;
        @(posedge S_AXI_ACLK); #1;
        S_AXI_AWADDR = a; S_AXI_AWVALID = 1'b1;
        while (1) begin
            @(negedge S_AXI_ACLK);
            if (S_AXI_AWREADY) break;
            if (++n > 50) begin check("aw_timeout", S_AXI_AWREADY, 1'b1); break; end
        end
        @(posedge S_AXI_ACLK); #1;
        S_AXI_AWVALID = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] d, input logic [3:0] s);
        int n = 0;
        @(posedge S_AXI_ACLK); #1;
        S_AXI_WDATA = d; S_AXI_WSTRB = s; S_AXI_WVALID = 1'b1;
        while (1) begin
            @(negedge S_AXI_ACLK);
            if (S_AXI_WREADY) break;
            if (++n > 50) begin check("w_timeout", S_AXI_WREADY, 1'b1); break; end
        end
        @(posedge S_AXI_ACLK); #1;
        S_AXI_WVALID = 1'b0;
    endtask

    task automatic send_ar(input logic [3:0] a);
        int n = 0;
        @(posedge S_AXI_ACLK); #1;
        S_AXI_ARADDR = a; S_AXI_ARVALID = 1'b1;
        while (1) begin
            @(negedge S_AXI_ACLK);
            if (S_AXI_ARREADY) break;
            if (++n > 50) begin check("ar_timeout", S_AXI_ARREADY, 1'b1); break; end
        end
        @(posedge S_AXI_ACLK); #1;
        S_AXI_ARVALID = 1'b0;
    endtask

    task automatic wait_b();
        int n = 0;
        while (1) begin
            @(negedge S_AXI_ACLK);
            if (S_AXI_BVALID && S_AXI_BREADY) break;
            if (++n > 50) begin check("b_timeout", S_AXI_BVALID, 1'b1); break; end
        end
        check("bresp", S_AXI_BRESP, AXI_RESP_OKAY);
        @(posedge S_AXI_ACLK); #1;
    endtask

    task automatic model_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
        for (int b = 0; b < 4; b++) if (s[b]) model[a[3:2]][8*b +: 8] = d[8*b +: 8];
    endtask

    task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
        fork
            send_aw(a);
            send_w(d, s);
        join
        wait_b();
        model_write(a, d, s);
    endtask

    task automatic axi_read(input logic [3:0] a);
        int n = 0;
        exp_q.push_back(model[a[3:2]]);
        send_ar(a);
        while (exp_q.size() != 0) begin
            @(negedge S_AXI_ACLK);
            if (++n > 50) begin
                check("r_timeout", S_AXI_RVALID, 1'b1);
                exp_q.delete();
            end
        end
        @(posedge S_AXI_ACLK); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4; i++) model[i] = '0;
        clear_wr_cnt();

        // Reset values
        #23;
        check("rst_awready", S_AXI_AWREADY, 1'b1);
        check("rst_wready",  S_AXI_WREADY,  1'b1);
        check("rst_arready", S_AXI_ARREADY, 1'b1);
        check("rst_bvalid",  S_AXI_BVALID,  1'b0);
        check("rst_rvalid",  S_AXI_RVALID,  1'b0);
        check("rst_rdata",   S_AXI_RDATA,   32'h0);
        check("rst_reg_o",   reg_o,         128'h0);
        check("rst_reg_wr",  reg_wr_o,      4'h0);
        @(negedge S_AXI_ACLK);
        S_AXI_ARESETN = 1'b1;

        // 1: burst of full writes, then read back
        axi_write(REG_CTRL,    32'h1, 4'hF);
        axi_write(REG_THRESH,  32'h2, 4'hF);
        axi_write(REG_GAIN,    32'h3, 4'hF);
        axi_write(REG_SCRATCH, 32'h4, 4'hF);
        for (int i = 0; i < 4; i++) check($sformatf("t1_wr_cnt%0d", i), wr_cnt[i], 1);
        check("t1_reg_o", reg_o, {32'h4, 32'h3, 32'h2, 32'h1});
        axi_read(REG_CTRL);
        axi_read(REG_THRESH);
        axi_read(REG_GAIN);
        axi_read(REG_SCRATCH);

        // 2: partial byte strobes
        axi_write(REG_CTRL, 32'h11223344, 4'hF);
        clear_wr_cnt();
        axi_write(REG_CTRL, 32'hAABBCCDD, 4'b0011);
        check("t2_model", model[0], 32'h1122CCDD);
        axi_read(REG_CTRL);
        check("t2_wr_cnt0", wr_cnt[0], 1);
        check("t2_wr_cnt_other", wr_cnt[1] + wr_cnt[2] + wr_cnt[3], 0);

        // WSTRB=0: acknowledged, value unchanged, pulse still issued
        clear_wr_cnt();
        axi_write(REG_GAIN, 32'hDEADBEEF, 4'b0000);
        check("strb0_wr_cnt2", wr_cnt[2], 1);
        axi_read(REG_GAIN);

        // 3: W leads AW by several cycles
        send_w(32'h0000_ABCD, 4'hF);
        @(negedge S_AXI_ACLK);
        check("t3_wready_low", S_AXI_WREADY, 1'b0);
        check("t3_bvalid_early", S_AXI_BVALID, 1'b0);
        @(negedge S_AXI_ACLK);
        check("t3_bvalid_wait", S_AXI_BVALID, 1'b0);
        send_aw(REG_THRESH);
        @(negedge S_AXI_ACLK);
        check("t3_bvalid", S_AXI_BVALID, 1'b1);
        check("t3_bresp", S_AXI_BRESP, AXI_RESP_OKAY);
        @(posedge S_AXI_ACLK); #1;
        model_write(REG_THRESH, 32'h0000_ABCD, 4'hF);
        axi_read(REG_THRESH);

        // 4: B back-pressure while reads keep flowing
        S_AXI_BREADY = 1'b0;
        fork
            send_aw(REG_SCRATCH);
            send_w(32'h0000_0077, 4'hF);
        join
        repeat (5) begin
            @(negedge S_AXI_ACLK);
            check("t4_bvalid",  S_AXI_BVALID,  1'b1);
            check("t4_awready", S_AXI_AWREADY, 1'b0);
            check("t4_wready",  S_AXI_WREADY,  1'b0);
        end
        axi_read(REG_GAIN);
        check("t4_bvalid_after_read", S_AXI_BVALID, 1'b1);
        S_AXI_BREADY = 1'b1;
        wait_b();
        @(negedge S_AXI_ACLK);
        check("t4_awready_back", S_AXI_AWREADY, 1'b1);
        check("t4_wready_back",  S_AXI_WREADY,  1'b1);
        model_write(REG_SCRATCH, 32'h0000_0077, 4'hF);
        axi_read(REG_SCRATCH);

        // 5: same-edge read and commit to one register returns the old value
        axi_write(REG_THRESH, 32'h5, 4'hF);
        fork
            axi_write(REG_THRESH, 32'h9, 4'hF);
            axi_read(REG_THRESH);
        join
        check("t5_model", model[1], 32'h9);
        axi_read(REG_THRESH);

        // 6: reset with R pending and AW half-accepted
        S_AXI_RREADY = 1'b0;
        send_ar(REG_CTRL);
        @(negedge S_AXI_ACLK);
        check("t6_rvalid_pending", S_AXI_RVALID, 1'b1);
        send_aw(REG_GAIN);
        @(negedge S_AXI_ACLK);
        check("t6_aw_held", S_AXI_AWREADY, 1'b0);
        #2 S_AXI_ARESETN = 1'b0;
        #1;
        check("t6_rvalid",  S_AXI_RVALID,  1'b0);
        check("t6_bvalid",  S_AXI_BVALID,  1'b0);
        check("t6_awready", S_AXI_AWREADY, 1'b1);
        check("t6_wready",  S_AXI_WREADY,  1'b1);
        check("t6_arready", S_AXI_ARREADY, 1'b1);
        check("t6_reg_o",   reg_o,         128'h0);
        check("t6_rdata",   S_AXI_RDATA,   32'h0);
        for (int i = 0; i < 4; i++) model[i] = '0;
        exp_q.delete();
        S_AXI_RREADY = 1'b1;
        repeat (2) @(negedge S_AXI_ACLK);
        S_AXI_ARESETN = 1'b1;
        axi_read(REG_GAIN);
        axi_write(REG_GAIN, 32'hCAFE_F00D, 4'hF);
        axi_read(REG_GAIN);
        axi_read(REG_CTRL);

        repeat (3) @(posedge S_AXI_ACLK);
        check("final_queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
